regfile_wb_arbiter: RTL

//  Shares the register file's single write port between two writeback requesters:
//  req0 is ALU/EX result, req1 is load/MEM result. Arbitration is round-robin with

---
 rtl/regfile_wb_arbiter_pkg.sv | 7 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 63 ++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths for the regfile writeback path.
package regfile_wb_arbiter_pkg;
    localparam int REG_ADDR_LEN = 5;
    localparam int DATA_LEN     = 32;
    localparam int REG_NUM      = 1 << REG_ADDR_LEN;
    localparam int WB_REQ_NUM   = 2;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational; only contested
// cycles move the priority pointer.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
#(
    parameter bit PRIO0 = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WB_REQ_NUM-1:0] valid,
    output logic [WB_REQ_NUM-1:0] grant
);
    // 1 = requester 0 won the most recent contested cycle
    logic last_grant;

    always_comb begin
        grant = '0;
        if (!rst) begin
            if (&valid)
                grant = last_grant ? 2'b10 : 2'b01;
            else
                grant = valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= ~PRIO0;
        else if (&valid)
            last_grant <= grant[0];
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between EX (req0) and MEM (req1) writeback,
// with a registered output stage and same-cycle read bypass of the staged write.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int AW    = REG_ADDR_LEN,
    parameter int DW    = DATA_LEN,
    parameter bit PRIO0 = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    input  logic [AW-1:0] byp_raddr1,
    input  logic [AW-1:0] byp_raddr2,
    output logic          byp_hit1,
    output logic          byp_hit2,
    output logic [DW-1:0] byp_data
);
    logic [WB_REQ_NUM-1:0] grant;
    logic [AW-1:0]         sel_addr;
    logic [DW-1:0]         sel_data;

    rr_arb2 #(.PRIO0(PRIO0)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign sel_addr   = grant[1] ? req1_addr : req0_addr;
    assign sel_data   = grant[1] ? req1_data : req0_data;

    // x0 writes are consumed but never staged; addr/data hold when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (|grant && sel_addr != '0) begin
            rf_we    <= 1'b1;
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign byp_hit1 = rf_we && (rf_waddr == byp_raddr1) && (byp_raddr1 != '0);
    assign byp_hit2 = rf_we && (rf_waddr == byp_raddr2) && (byp_raddr2 != '0);
    assign byp_data = rf_wdata;
endmodule
